wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter driving the integer register file's single write port (wb_en / wb_addr / wb_data). It merges two result sources: an ALU stream that cannot stall and a load/memory stream with a valid/ready handshake. Load results are buffered in a small FIFO. The block also exports a per-register pending vector so issue logic can hold back reads of registers whose writes are still queued.

## Interface
- XLEN, 64: data width.
- DEPTH, 4: load FIFO entries; a power of two, ≥ 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; asserting it (0) clears all state immediately.
- alu_valid  in  1  ALU result present this cycle; no backpressure.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- mem_valid  in  1  load result offered.
- mem_ready  out  1  load result accepted when mem_valid && mem_ready.
- mem_rd  in  5  load destination register.
- mem_data  in  XLEN  load result.
- wb_en  out  1  register-file write enable (registered).
- wb_addr  out  5  register-file write address (registered).
- wb_data  out  XLEN  register-file write data (registered).
- pending  out  32  bit r = 1 while any FIFO entry targets register r.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Reset (reset=0):
  - FIFO emptied; queued entries are discarded.
  - wb_en=0, wb_addr=0, wb_data=0, pending=0, fifo_count=0.
  - mem_ready=1.
- Output register select, evaluated each cycle in priority order:
  1. alu_valid && alu_rd≠0: load ALU result; wb_en=1.
  2. Otherwise, FIFO non-empty: pop head into output; wb_en=1.
  3. Otherwise: wb_en=0; wb_addr and wb_data hold their previous values.
- ALU writes have fixed priority. Continuous ALU traffic starves the FIFO; this is accepted.
- x0 handling:
  - An ALU request with alu_rd=0 is ignored and does not block a FIFO pop.
  - A load with mem_rd=0 is accepted (handshake completes) but not enqueued.
- mem_ready = (fifo_count < DEPTH), computed from current state.
  - When full, ready stays 0 even if a pop occurs this cycle; there is no full-pass-through.
- Push and pop in the same cycle are legal: count is unchanged, and the pointers wrap modulo DEPTH.
- pending is combinational over the valid FIFO entries.
  - It does not include the entry currently in the output register.
  - That register is written at the next edge, so a read of it in the following cycle sees the new value.
- Write ordering between ALU and FIFO for the same rd is not resolved here. Issue logic must use pending to stall.

## Timing
- ALU: alu_valid at edge N produces wb_en=1 in cycle N+1. Latency 1.
- Load, FIFO path: accepted at edge N, enqueued at N; earliest wb_en in cycle N+2. Latency 2.
- pending[r] rises in the cycle after acceptance. It falls in the cycle after the entry is popped, i.e. the same cycle its wb_en=1 is visible.
- fifo_count is updated at the same edge as the push/pop.

## Configuration
- WB_BYPASS_EN defined: a load bypasses the FIFO when all of the following hold at the same edge:
  - it is accepted (mem_valid && mem_ready);
  - the FIFO is empty;
  - no ALU write is selected.
  - Effect: the load goes directly into the output register, so wb_en=1 in the next cycle (latency 1). pending is never set for it, and fifo_count stays 0.
- WB_BYPASS_EN undefined: every non-x0 load passes through the FIFO (latency ≥ 2).

## Test plan
- Reset: hold reset=0 with random inputs → wb_en=0, pending=0, fifo_count=0, mem_ready=1; release → first alu_valid with rd=5, data=0xAA yields wb_en=1, wb_addr=5, wb_data=0xAA one cycle later.
- Priority: same cycle alu(rd=3, 0x11) and mem(rd=4, 0x22), FIFO empty → cycle+1 writes r3=0x11; cycle+2 writes r4=0x22. pending[4]=1 for exactly one cycle, and bypass does not fire in either build.
- Full/backpressure: alu_valid=1 continuously, push 4 loads (rd=1..4) → fifo_count=4, mem_ready=0, pending=0x1E. Drop alu_valid → drains r1..r4 in order over 4 cycles; mem_ready returns to 1 the cycle after the first pop.
- x0: alu rd=0 plus a queued load rd=7 → pop happens that cycle, so wb_addr=7. mem rd=0 accepted → fifo_count unchanged, no write.
- Wrap-around: 10 back-to-back loads with alu idle, DEPTH=4 → 10 writes in order, with no loss or duplication.
- Bypass: with WB_BYPASS_EN, FIFO empty, a single load (rd=9, 0x55) → wb_en=1 next cycle and pending[9] never set. Without the macro → wb_en at cycle+2 and pending[9]=1 for one cycle.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU result stream, load handshake and register-file write port.
interface wb_arbiter_if #(
  parameter int XLEN = 64
);
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  // Producer side: the ALU/load units and the register file.
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  mem_ready, wb_en, wb_addr, wb_data
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output mem_ready, wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: fixed-priority ALU stream over a load FIFO, with a per-register pending vector.
// Optional feature: define WB_BYPASS_EN to let a load skip the empty FIFO straight into the output register.
module wb_arbiter #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  wb_arbiter_if.slave            bus,
  output logic [31:0]            pending,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [4:0]      fifo_rd   [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [AW:0]     count;

  logic alu_sel, accept, pop, push, bypass;

  // Ready depends only on current occupancy: a full FIFO refuses even when it pops this cycle.
  assign bus.mem_ready = (count < (AW+1)'(DEPTH));
  assign fifo_count    = count;

  always_comb begin
    alu_sel = bus.alu_valid && (bus.alu_rd != 5'd0);
    accept  = bus.mem_valid && bus.mem_ready;
    pop     = !alu_sel && (count != '0);
`ifdef WB_BYPASS_EN
    bypass  = accept && (bus.mem_rd != 5'd0) && (count == '0) && !alu_sel;
`else
    bypass  = 1'b0;
`endif
    // x0 loads complete the handshake but are never stored.
    push    = accept && (bus.mem_rd != 5'd0) && !bypass;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: entry storage has no reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[tail] <= bus.mem_data;
      fifo_rd[tail]   <= bus.mem_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.wb_en   <= 1'b0;
      bus.wb_addr <= '0;
      bus.wb_data <= '0;
    end else if (alu_sel) begin
      bus.wb_en   <= 1'b1;
      bus.wb_addr <= bus.alu_rd;
      bus.wb_data <= bus.alu_data;
    end else if (pop) begin
      bus.wb_en   <= 1'b1;
      bus.wb_addr <= fifo_rd[head];
      bus.wb_data <= fifo_data[head];
    end else if (bypass) begin
      bus.wb_en   <= 1'b1;
      bus.wb_addr <= bus.mem_rd;
      bus.wb_data <= bus.mem_data;
    end else begin
      bus.wb_en   <= 1'b0;
    end
  end

  // A slot is live when its distance from head (mod DEPTH) is below the occupancy.
  logic [AW-1:0] offs;
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a variable unassigned (no latch).
    pending = '0;
    offs    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = AW'(i) - head;
      if ({1'b0, offs} < count) pending[fifo_rd[i]] = 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed plan steps plus random traffic against a queue-based model.
module tb_wb_arbiter;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] pending;
  logic [$clog2(DEPTH):0] fifo_count;

  wb_arbiter_if #(.XLEN(XLEN)) b ();

  wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (b.slave),
    .pending    (pending),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queued loads in arrival order plus the expected write-port registers.
  entry_t          q[$];
  logic            m_en;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (q[i]) p[q[i].rd] = 1'b1;
    return p;
  endfunction

  task automatic drive(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [XLEN-1:0] md);
    b.alu_valid = av; b.alu_rd = ard; b.alu_data = ad;
    b.mem_valid = mv; b.mem_rd = mrd; b.mem_data = md;
  endtask

  // One clock: drive inputs, check combinational outputs, advance model, check registered outputs.
  task automatic step(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                      input logic mv, input logic [4:0] mrd, input logic [XLEN-1:0] md);
    bit alu_sel, accept, took_bypass;
    entry_t e;
    drive(av, ard, ad, mv, mrd, md);
    #2;
    chk("mem_ready",  XLEN'(b.mem_ready), XLEN'(q.size() < DEPTH));
    chk("fifo_count", XLEN'(fifo_count),  XLEN'(q.size()));
    chk("pending",    XLEN'(pending),     XLEN'(model_pending()));
    alu_sel     = av && (ard != 0);
    accept      = mv && (q.size() < DEPTH);
    took_bypass = 1'b0;
    if (alu_sel) begin
      m_en = 1'b1; m_addr = ard; m_data = ad;
    end else if (q.size() != 0) begin
      e = q.pop_front();
      m_en = 1'b1; m_addr = e.rd; m_data = e.data;
    end else if (BYP && accept && mrd != 0) begin
      m_en = 1'b1; m_addr = mrd; m_data = md; took_bypass = 1'b1;
    end else begin
      m_en = 1'b0;
    end
    if (accept && mrd != 0 && !took_bypass) begin
      e.rd = mrd; e.data = md;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("wb_en",   XLEN'(b.wb_en),   XLEN'(m_en));
    chk("wb_addr", XLEN'(b.wb_addr), XLEN'(m_addr));
    chk("wb_data", b.wb_data,        m_data);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  initial begin
    // Reset held with random inputs: outputs must stay in their cleared state.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'($urandom), 5'($urandom), {$urandom, $urandom}, 1'($urandom), 5'($urandom), {$urandom, $urandom});
      @(negedge clk);
      chk("rst_wb_en",     XLEN'(b.wb_en),     '0);
      chk("rst_wb_addr",   XLEN'(b.wb_addr),   '0);
      chk("rst_wb_data",   b.wb_data,          '0);
      chk("rst_pending",   XLEN'(pending),     '0);
      chk("rst_count",     XLEN'(fifo_count),  '0);
      chk("rst_mem_ready", XLEN'(b.mem_ready), 64'd1);
    end
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_en = 1'b0; m_addr = '0; m_data = '0;

    // First ALU write after release.
    step(1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, '0);
    chk("first_alu_addr", XLEN'(b.wb_addr), 64'd5);
    idle();

    // ALU and load in the same cycle: ALU first, load one cycle later, pending[4] for one cycle.
    step(1'b1, 5'd3, 64'h11, 1'b1, 5'd4, 64'h22);
    chk("prio_alu_addr", XLEN'(b.wb_addr), 64'd3);
    chk("prio_pending4", XLEN'(pending[4]), 64'd1);
    idle();
    chk("prio_load_addr", XLEN'(b.wb_addr), 64'd4);
    idle();

    // Fill the FIFO under continuous ALU traffic, then drain.
    for (int i = 1; i <= 4; i++)
      step(1'b1, 5'(9 + i), XLEN'(i), 1'b1, 5'(i), XLEN'(64'h100 + i));
    step(1'b1, 5'd20, 64'h7, 1'b1, 5'd21, 64'hDEAD);   // refused: FIFO full
    chk("full_pending", XLEN'(pending), 64'h1E);
    for (int i = 0; i < 6; i++) idle();

    // x0 handling.
    step(1'b1, 5'd2, 64'h3, 1'b1, 5'd7, 64'h77);
    step(1'b1, 5'd0, 64'h99, 1'b0, 5'd0, '0);
    chk("x0_alu_pop", XLEN'(b.wb_addr), 64'd7);
    step(1'b0, 5'd0, '0, 1'b1, 5'd0, 64'h5A);
    chk("x0_load_nowrite", XLEN'(b.wb_en), 64'd0);
    idle();

    // Ten back-to-back loads with the ALU idle.
    for (int i = 0; i < 10; i++)
      step(1'b0, 5'd0, '0, 1'b1, 5'(i + 11), XLEN'(64'h1000 + i));
    for (int i = 0; i < 3; i++) idle();

    // Single load into an empty FIFO: bypass build writes next cycle, otherwise one cycle later.
    step(1'b0, 5'd0, '0, 1'b1, 5'd9, 64'h55);
    chk("byp_wb_en", XLEN'(b.wb_en), XLEN'(BYP));
    idle();
    chk("byp_addr", XLEN'(b.wb_addr), 64'd9);
    idle();

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 2) == 0), 5'($urandom), {$urandom, $urandom},
           ($urandom_range(0, 3) != 0), 5'($urandom), {$urandom, $urandom});

    // Asynchronous reset mid-cycle with queued entries.
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'(i + 1), XLEN'(i), 1'b1, 5'(i + 20), XLEN'(i));
    #2;
    reset = 1'b0;
    #1;
    chk("async_count",     XLEN'(fifo_count),  '0);
    chk("async_pending",   XLEN'(pending),     '0);
    chk("async_wb_en",     XLEN'(b.wb_en),     '0);
    chk("async_mem_ready", XLEN'(b.mem_ready), 64'd1);
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    q.delete();
    m_en = 1'b0; m_addr = '0; m_data = '0;
    for (int i = 0; i < 20; i++)
      step(($urandom_range(0, 1) == 0), 5'($urandom), {$urandom, $urandom},
           1'b1, 5'($urandom), {$urandom, $urandom});
    for (int i = 0; i < 6; i++) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
